// File: rtl/cop_pkg.sv
// Shared opcode map and issue-FSM encodings for the matrix coprocessor front end.
package cop_pkg;

  localparam int unsigned OPC_LSB = 0;
  localparam int unsigned OPC_W   = 4;

  localparam logic [OPC_W-1:0] OP_READ  = 4'd1;
  localparam logic [OPC_W-1:0] OP_WRITE = 4'd2;
  localparam logic [OPC_W-1:0] OP_SUM   = 4'd3;
  localparam logic [OPC_W-1:0] OP_SUB   = 4'd4;
  localparam logic [OPC_W-1:0] OP_MUL   = 4'd5;
  localparam logic [OPC_W-1:0] OP_TRANS = 4'd6;
  localparam logic [OPC_W-1:0] OP_SCALE = 4'd7;
  localparam logic [OPC_W-1:0] OP_DET2  = 4'd8;
  localparam logic [OPC_W-1:0] OP_DET3  = 4'd9;
  localparam logic [OPC_W-1:0] OP_DET4  = 4'd10;
  localparam logic [OPC_W-1:0] OP_DET5  = 4'd11;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StWaitStart,
    StWaitDone
  } iq_state_e;

  function automatic logic [OPC_W-1:0] get_opc(input logic [31:0] instr);
    return instr[OPC_LSB +: OPC_W];
  endfunction

endpackage

// File: rtl/instr_fifo.sv
// Synchronous FIFO with first-word-fall-through head; pushes while full are ignored.
module instr_fifo #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       wdata,
  output logic [WIDTH-1:0]       rdata,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  assign full    = (count_q == (AW+1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rdata   = mem_q[rd_ptr_q];
  assign count   = count_q;

  always_comb begin
    // Power-of-two depth: pointers wrap by natural overflow
    wr_ptr_d = wr_ptr_q + AW'(do_push);
    rd_ptr_d = rd_ptr_q + AW'(do_pop);
    count_d  = count_q;
    if (do_push && !do_pop) begin
      count_d = count_q + 1'b1;
    end else if (!do_push && do_pop) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= wdata;
    end
  end

endmodule

// File: rtl/instr_issue_queue.sv
// Buffers HPS-written instructions and issues them one at a time to the matrix coprocessor.
// Optional build macro ISSUE_TIMEOUT_EN adds a cop_busy watchdog and the err_timeout flag.
module instr_issue_queue
  import cop_pkg::*;
#(
  parameter int unsigned DEPTH      = 8,
  parameter int unsigned START_WAIT = 4,
  parameter int unsigned TIMEOUT    = 4096
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [31:0]            hps_instr,
  input  logic                   hps_wr,
  input  logic                   clear_status,
  input  logic                   result_ack,
  input  logic                   cop_busy,
  input  logic [15:0]            cop_data_read,
  input  logic                   cop_overflow,
  output logic [31:0]            cop_instruction,
  output logic                   cop_activate,
  output logic [$clog2(DEPTH):0] fifo_count,
  output logic                   fifo_full,
  output logic                   busy,
  output logic [15:0]            result_data,
  output logic                   result_valid,
  output logic                   err_drop,
  output logic                   err_start,
`ifdef ISSUE_TIMEOUT_EN
  output logic                   err_timeout,
`endif
  output logic                   overflow_sticky
);

  localparam int unsigned CntW = $clog2(START_WAIT + TIMEOUT + 1);

  iq_state_e   state_q, state_d;
  logic        hps_wr_q;
  logic [31:0] instr_q, instr_d;
  logic        act_q, act_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [15:0] rdata_q, rdata_d;
  logic        rvalid_q, rvalid_d;
  logic        err_drop_q, err_drop_d;
  logic        err_start_q, err_start_d;
  logic        ovf_q, ovf_d;
`ifdef ISSUE_TIMEOUT_EN
  logic        err_to_q, err_to_d;
`endif

  logic        push_req, pop, fifo_empty;
  logic [31:0] head;

  assign push_req = hps_wr & ~hps_wr_q;

  instr_fifo #(
    .DEPTH(DEPTH),
    .WIDTH(32)
  ) u_fifo (
    .clk  (clk),
    .rst_n(rst_n),
    .push (push_req),
    .pop  (pop),
    .wdata(hps_instr),
    .rdata(head),
    .count(fifo_count),
    .full (fifo_full),
    .empty(fifo_empty)
  );

  always_comb begin
    state_d     = state_q;
    instr_d     = instr_q;
    act_d       = 1'b0;
    cnt_d       = cnt_q;
    rdata_d     = rdata_q;
    rvalid_d    = rvalid_q;
    err_drop_d  = err_drop_q;
    err_start_d = err_start_q;
    ovf_d       = ovf_q;
`ifdef ISSUE_TIMEOUT_EN
    err_to_d    = err_to_q;
`endif
    pop         = 1'b0;

    // Clears first so that a same-cycle set event wins
    if (clear_status) begin
      err_drop_d  = 1'b0;
      err_start_d = 1'b0;
      ovf_d       = 1'b0;
`ifdef ISSUE_TIMEOUT_EN
      err_to_d    = 1'b0;
`endif
    end
    if (result_ack) rvalid_d = 1'b0;
    if (push_req && fifo_full) err_drop_d = 1'b1;

    unique case (state_q)
      StIdle: begin
        // A READ at the head stalls until the previous result is acknowledged
        if (!fifo_empty && !cop_busy && !(get_opc(head) == OP_READ && rvalid_q)) begin
          pop     = 1'b1;
          instr_d = head;
          act_d   = 1'b1;
          state_d = StIssue;
        end
      end
      StIssue: begin
        cnt_d   = '0;
        state_d = StWaitStart;
      end
      StWaitStart: begin
        if (cop_busy) begin
          cnt_d   = '0;
          state_d = StWaitDone;
        end else if (cnt_q == CntW'(START_WAIT - 1)) begin
          err_start_d = 1'b1;
          state_d     = StIdle;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StWaitDone: begin
        if (!cop_busy) begin
          ovf_d = ovf_d | cop_overflow;
          if (get_opc(instr_q) == OP_READ) begin
            rdata_d  = cop_data_read;
            rvalid_d = 1'b1;
          end
          state_d = StIdle;
`ifdef ISSUE_TIMEOUT_EN
        end else if (cnt_q == CntW'(TIMEOUT - 1)) begin
          err_to_d = 1'b1;
          state_d  = StIdle;
        end else begin
          cnt_d = cnt_q + 1'b1;
`endif
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      hps_wr_q    <= 1'b0;
      instr_q     <= '0;
      act_q       <= 1'b0;
      cnt_q       <= '0;
      rdata_q     <= '0;
      rvalid_q    <= 1'b0;
      err_drop_q  <= 1'b0;
      err_start_q <= 1'b0;
      ovf_q       <= 1'b0;
`ifdef ISSUE_TIMEOUT_EN
      err_to_q    <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      hps_wr_q    <= hps_wr;
      instr_q     <= instr_d;
      act_q       <= act_d;
      cnt_q       <= cnt_d;
      rdata_q     <= rdata_d;
      rvalid_q    <= rvalid_d;
      err_drop_q  <= err_drop_d;
      err_start_q <= err_start_d;
      ovf_q       <= ovf_d;
`ifdef ISSUE_TIMEOUT_EN
      err_to_q    <= err_to_d;
`endif
    end
  end

  assign cop_instruction = instr_q;
  assign cop_activate    = act_q;
  assign busy            = (state_q != StIdle) | ~fifo_empty;
  assign result_data     = rdata_q;
  assign result_valid    = rvalid_q;
  assign err_drop        = err_drop_q;
  assign err_start       = err_start_q;
  assign overflow_sticky = ovf_q;
`ifdef ISSUE_TIMEOUT_EN
  assign err_timeout     = err_to_q;
`endif

endmodule

// File: tb/tb_instr_issue_queue.sv
// Directed bench for instr_issue_queue with a coprocessor model and in-order issue scoreboard.
module tb_instr_issue_queue;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] hps_instr = '0;
  logic        hps_wr = 1'b0;
  logic        clear_status = 1'b0;
  logic        result_ack = 1'b0;
  logic        cop_busy;
  logic [15:0] cop_data_read = '0;
  logic        cop_overflow = 1'b0;
  logic [31:0] cop_instruction;
  logic        cop_activate;
  logic [3:0]  fifo_count;
  logic        fifo_full, busy, result_valid, err_drop, err_start, overflow_sticky;
  logic [15:0] result_data;
`ifdef ISSUE_TIMEOUT_EN
  logic        err_timeout;
`endif

  int n_cmp = 0;
  int n_fail = 0;
  int act_count = 0;
  logic [31:0] sb [$];

  // Coprocessor model
  logic respond = 1'b1;
  logic force_busy = 1'b0;
  int   busy_len = 5;
  int   mcnt = 0;

  assign cop_busy = force_busy | (mcnt != 0);

  always #5 clk = ~clk;

  instr_issue_queue #(
    .DEPTH(8),
    .START_WAIT(4),
    .TIMEOUT(4096)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .hps_instr      (hps_instr),
    .hps_wr         (hps_wr),
    .clear_status   (clear_status),
    .result_ack     (result_ack),
    .cop_busy       (cop_busy),
    .cop_data_read  (cop_data_read),
    .cop_overflow   (cop_overflow),
    .cop_instruction(cop_instruction),
    .cop_activate   (cop_activate),
    .fifo_count     (fifo_count),
    .fifo_full      (fifo_full),
    .busy           (busy),
    .result_data    (result_data),
    .result_valid   (result_valid),
    .err_drop       (err_drop),
    .err_start      (err_start),
`ifdef ISSUE_TIMEOUT_EN
    .err_timeout    (err_timeout),
`endif
    .overflow_sticky(overflow_sticky)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  always @(posedge clk) begin
    if (cop_activate && respond) mcnt <= busy_len;
    else if (mcnt > 0) mcnt <= mcnt - 1;
  end

  // Every issue strobe must carry the oldest accepted word
  always @(negedge clk) begin
    if (cop_activate) begin
      act_count++;
      if (sb.size() == 0) begin
        check("unexpected_issue", cop_instruction, 32'hxxxx_xxxx);
      end else begin
        check("issue_order", cop_instruction, sb.pop_front());
      end
    end
  end

  task automatic push_word(input logic [31:0] w, input bit accept);
    @(negedge clk);
    hps_wr = 1'b1;
    hps_instr = w;
    if (accept) sb.push_back(w);
    @(negedge clk);
    hps_wr = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int k;
    for (k = 0; k < budget; k++) begin
      @(negedge clk);
      if (!busy && !cop_busy && !cop_activate) break;
    end
    check("wait_idle_budget", 32'(k < budget), 32'd1);
  endtask

  task automatic pulse_clear();
    @(negedge clk);
    clear_status = 1'b1;
    @(negedge clk);
    clear_status = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_instr"}, cop_instruction, 32'h0);
    check({tag, "_act"}, 32'(cop_activate), 32'h0);
    check({tag, "_count"}, 32'(fifo_count), 32'h0);
    check({tag, "_busy"}, 32'(busy), 32'h0);
    check({tag, "_rdata"}, 32'(result_data), 32'h0);
    check({tag, "_rvalid"}, 32'(result_valid), 32'h0);
    check({tag, "_errs"}, {29'h0, err_drop, err_start, overflow_sticky}, 32'h0);
  endtask

  initial begin
    int a0;
    // Reset state
    #12;
    check_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Single WRITE: strobe in the third cycle counting the push cycle
    @(negedge clk);
    hps_instr = 32'h0000_0012;
    hps_wr = 1'b1;
    sb.push_back(32'h0000_0012);
    @(negedge clk);
    hps_wr = 1'b0;
    check("lat_not_early", 32'(cop_activate), 32'd0);
    @(negedge clk);
    check("lat_activate", 32'(cop_activate), 32'd1);
    check("lat_instr", cop_instruction, 32'h0000_0012);
    @(negedge clk);
    check("act_one_cycle", 32'(cop_activate), 32'd0);
    check("instr_held", cop_instruction, 32'h0000_0012);
    wait_idle(30);
    check("write_no_result", 32'(result_valid), 32'd0);

    // READ capture, then a second READ stalls until ack
    cop_data_read = 16'hBEEF;
    push_word(32'h0000_0031, 1'b1);
    wait_idle(30);
    check("read_valid", 32'(result_valid), 32'd1);
    check("read_data", 32'(result_data), 32'h0000_BEEF);
    a0 = act_count;
    cop_data_read = 16'h1234;
    push_word(32'h0000_0041, 1'b1);
    repeat (10) @(negedge clk);
    check("stall_count", 32'(fifo_count), 32'd1);
    check("stall_no_issue", 32'(act_count - a0), 32'd0);
    check("stall_data_kept", 32'(result_data), 32'h0000_BEEF);
    @(negedge clk);
    result_ack = 1'b1;
    @(negedge clk);
    result_ack = 1'b0;
    wait_idle(30);
    check("read2_issued", 32'(act_count - a0), 32'd1);
    check("read2_valid", 32'(result_valid), 32'd1);
    check("read2_data", 32'(result_data), 32'h0000_1234);
    @(negedge clk);
    result_ack = 1'b1;
    @(negedge clk);
    result_ack = 1'b0;
    check("ack_clears", 32'(result_valid), 32'd0);

    // Overfill with coprocessor held busy
    force_busy = 1'b1;
    a0 = act_count;
    for (int i = 0; i < 9; i++) push_word({24'h0000A0 + 24'(i), 8'h02}, i < 8);
    @(negedge clk);
    check("full_flag", 32'(fifo_full), 32'd1);
    check("full_count", 32'(fifo_count), 32'd8);
    check("err_drop", 32'(err_drop), 32'd1);
    force_busy = 1'b0;
    wait_idle(200);
    check("drain_issues", 32'(act_count - a0), 32'd8);
    check("drain_sb_empty", 32'(sb.size()), 32'd0);
    pulse_clear();
    check("drop_cleared", 32'(err_drop), 32'd0);

    // No busy response: start error
    respond = 1'b0;
    push_word(32'h0000_0022, 1'b1);
    wait_idle(20);
    check("err_start_set", 32'(err_start), 32'd1);
    check("start_fsm_idle", 32'(busy), 32'd0);
    respond = 1'b1;
    pulse_clear();
    check("err_start_clr", 32'(err_start), 32'd0);

    // Overflow stickiness across a clean op
    cop_overflow = 1'b1;
    push_word(32'h0000_0003, 1'b1);
    wait_idle(30);
    cop_overflow = 1'b0;
    check("ovf_set", 32'(overflow_sticky), 32'd1);
    push_word(32'h0000_0004, 1'b1);
    wait_idle(30);
    check("ovf_persist", 32'(overflow_sticky), 32'd1);

`ifdef ISSUE_TIMEOUT_EN
    busy_len = 5000;
    push_word(32'h0000_0005, 1'b1);
    a0 = 0;
    while (!err_timeout && a0 < 4300) begin
      @(negedge clk);
      a0++;
    end
    check("err_timeout", 32'(err_timeout), 32'd1);
    wait_idle(1200);
    busy_len = 5;
    pulse_clear();
    check("timeout_clr", 32'(err_timeout), 32'd0);
    push_word(32'h0000_0003, 1'b1);
    cop_overflow = 1'b1;
    wait_idle(30);
    cop_overflow = 1'b0;
`endif

    // Asynchronous reset during WAIT_DONE
    busy_len = 20;
    push_word(32'h0000_0052, 1'b1);
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check_all_zero("midreset");
    @(negedge clk);
    rst_n = 1'b1;
    busy_len = 5;
    a0 = act_count;
    push_word(32'h0000_0062, 1'b1);
    repeat (3) @(negedge clk);
    check("hold_while_busy", 32'(act_count - a0), 32'd0);
    check("held_queued", 32'(fifo_count), 32'd1);
    wait_idle(60);
    check("post_reset_issue", 32'(act_count - a0), 32'd1);
    check("final_sb_empty", 32'(sb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
